bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_TENURE, default 16, maximum consecutive cycles master 1 may own the bus (legal 1..255).
REQ-002 SHALL have parameter CORE_SLICE, default 1, minimum COMMIT pulses the core retires between master-1 tenures (legal 0..15).
REQ-003 SHALL have ports: CLK in 1, system clock; RESET in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: COMMIT in 1, core instruction-end phase; HOLD out 1, freeze core phase sequencer.
REQ-005 SHALL have core bus inputs: CORE_ADDR in 16; CORE_DOUT in 16; CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN in 1 each, all active-low.
REQ-006 SHALL have master-1 ports: M1_REQ in 1; M1_GNT out 1; M1_ADDR in 16; M1_DOUT in 16; M1_RDN, M1_WRN0, M1_WRN1, M1_DBUS_OEN in 1 each, active-low.
REQ-007 SHALL have external bus outputs: ADDR_BUF out 16; DOUT_BUF out 16; RDN_BUF, WRN0_BUF, WRN1_BUF, DBUS_OEN out 1 each, active-low.

Function
REQ-008 SHALL implement states CORE, TURN_IN, DMA, TURN_OUT, with registered state and outputs HOLD and M1_GNT decoded from state.
REQ-009 CORE: bus outputs SHALL combinationally follow the CORE_* inputs; HOLD=0; M1_GNT=0.
REQ-010 DMA: bus outputs SHALL combinationally follow the M1_* inputs; HOLD=1; M1_GNT=1.
REQ-011 TURN_IN/TURN_OUT: RDN_BUF, WRN0_BUF, WRN1_BUF and DBUS_OEN SHALL be 1; ADDR_BUF and DOUT_BUF SHALL hold the values of the previous cycle; HOLD=1; M1_GNT=0.
REQ-012 Slice counter (4 bit) SHALL increment on each COMMIT=1 cycle in CORE, saturating at CORE_SLICE, and clear on entry to CORE from TURN_OUT/DMA.
REQ-013 CORE->TURN_IN SHALL occur at the clock edge where M1_REQ=1, COMMIT=1, and slice count >= CORE_SLICE, or >= CORE_SLICE-1 when that same COMMIT is counting.
REQ-014 TURN_IN->DMA SHALL occur after exactly one cycle if M1_REQ=1; if M1_REQ=0, TURN_IN->CORE.
REQ-015 Tenure counter (8 bit) SHALL clear on DMA entry and increment each DMA cycle.
REQ-016 DMA->TURN_OUT SHALL occur when M1_REQ=0, or when tenure count = MAX_TENURE-1; forced exit takes priority over a still-asserted M1_REQ.
REQ-017 TURN_OUT->CORE SHALL occur after exactly one cycle, unconditionally.
REQ-018 Grant latency from the qualifying COMMIT edge to M1_GNT=1 SHALL be 2 cycles; release latency from M1_REQ=0 sampled to HOLD=0 SHALL be 2 cycles.
REQ-019 COMMIT SHALL be ignored outside CORE; M1_REQ toggling in TURN_OUT SHALL have no effect.
REQ-020 Master 1 SHALL NOT be re-granted until CORE_SLICE further COMMITs occur after a tenure; CORE_SLICE=0 permits re-grant on the first COMMIT.

Reset
REQ-021 RESET=0 SHALL asynchronously force state CORE, HOLD=0, M1_GNT=0, and both counters to 0, including mid-tenure in DMA.
REQ-022 After reset, bus outputs SHALL follow the CORE_* inputs immediately.
REQ-023 Reset release SHALL be sampled synchronously; the first arbitration decision occurs on the first CLK edge with RESET=1.

Configuration
REQ-024 Macro BUS_ARBITER_TURNAROUND_EN defined: TURN_IN/TURN_OUT SHALL be present, giving one idle bus cycle on every ownership change.
REQ-025 Macro BUS_ARBITER_TURNAROUND_EN undefined: TURN_IN and TURN_OUT SHALL be omitted; CORE->DMA and DMA->CORE switch directly on the REQ-013/REQ-016 conditions; grant and release latency SHALL each be 1 cycle.

Verification
REQ-026 Reset: RESET=0 during DMA with tenure=5 -> same instant M1_GNT=0, HOLD=0, RDN_BUF=CORE_RDN.
REQ-027 Basic grant with macro on and CORE_SLICE=1: M1_REQ=1, COMMIT pulse at cycle 10 -> HOLD=1 at 11, M1_GNT=1 at 12, ADDR_BUF=M1_ADDR=0x8000 at 12.
REQ-028 Tenure limit: MAX_TENURE=4, M1_REQ held -> M1_GNT high exactly 4 cycles, then TURN_OUT, then CORE; no re-grant until the next COMMIT.
REQ-029 Fairness: CORE_SLICE=3, M1_REQ held -> after release, re-grant only after the third COMMIT; count 3 COMMITs between tenures.
REQ-030 Turnaround: during TURN_IN/TURN_OUT -> RDN_BUF=WRN0_BUF=WRN1_BUF=DBUS_OEN=1 and ADDR_BUF unchanged.
REQ-031 Abort: M1_REQ drops in TURN_IN -> CORE next cycle, M1_GNT never asserted; macro off -> same test shows 1-cycle grant/release latency.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: the core owns the bus by default; master 1 is granted
// between core instructions. Define BUS_ARBITER_TURNAROUND_EN for idle turnaround cycles.
module bus_arbiter #(
    parameter int MAX_TENURE = 16,
    parameter int CORE_SLICE = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        COMMIT,
    output logic        HOLD,
    input  logic [15:0] CORE_ADDR,
    input  logic [15:0] CORE_DOUT,
    input  logic        CORE_RDN,
    input  logic        CORE_WRN0,
    input  logic        CORE_WRN1,
    input  logic        CORE_DBUS_OEN,
    input  logic        M1_REQ,
    output logic        M1_GNT,
    input  logic [15:0] M1_ADDR,
    input  logic [15:0] M1_DOUT,
    input  logic        M1_RDN,
    input  logic        M1_WRN0,
    input  logic        M1_WRN1,
    input  logic        M1_DBUS_OEN,
    output logic [15:0] ADDR_BUF,
    output logic [15:0] DOUT_BUF,
    output logic        RDN_BUF,
    output logic        WRN0_BUF,
    output logic        WRN1_BUF,
    output logic        DBUS_OEN
);
    typedef enum logic [1:0] {
        S_CORE     = 2'd0,
        S_TURN_IN  = 2'd1,
        S_DMA      = 2'd2,
        S_TURN_OUT = 2'd3
    } state_t;

    localparam logic [4:0] SLICE    = 5'(CORE_SLICE);
    localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);

    state_t     state;
    logic [3:0] slice_cnt;
    logic [7:0] tenure_cnt;
    logic       grant_ok;
    logic       slice_inc;
    logic       dma_exit;

    // The COMMIT that qualifies also counts, hence the +1.
    assign grant_ok  = M1_REQ && COMMIT && (({1'b0, slice_cnt} + 5'd1) >= SLICE);
    assign slice_inc = COMMIT && ({1'b0, slice_cnt} < SLICE);
    assign dma_exit  = !M1_REQ || (tenure_cnt == TEN_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_CORE;
            HOLD       <= 1'b0;
            M1_GNT     <= 1'b0;
            slice_cnt  <= 4'd0;
            tenure_cnt <= 8'd0;
        end else begin
            case (state)
                S_CORE: begin
                    if (slice_inc)
                        slice_cnt <= slice_cnt + 4'd1;
                    if (grant_ok) begin
`ifdef BUS_ARBITER_TURNAROUND_EN
                        state <= S_TURN_IN;
                        HOLD  <= 1'b1;
`else
                        state      <= S_DMA;
                        HOLD       <= 1'b1;
                        M1_GNT     <= 1'b1;
                        tenure_cnt <= 8'd0;
`endif
                    end
                end
`ifdef BUS_ARBITER_TURNAROUND_EN
                S_TURN_IN: begin
                    if (M1_REQ) begin
                        state      <= S_DMA;
                        M1_GNT     <= 1'b1;
                        tenure_cnt <= 8'd0;
                    end else begin
                        state <= S_CORE;
                        HOLD  <= 1'b0;
                    end
                end
                S_TURN_OUT: begin
                    state     <= S_CORE;
                    HOLD      <= 1'b0;
                    slice_cnt <= 4'd0;
                end
`endif
                S_DMA: begin
                    tenure_cnt <= tenure_cnt + 8'd1;
                    if (dma_exit) begin
                        M1_GNT <= 1'b0;
`ifdef BUS_ARBITER_TURNAROUND_EN
                        state <= S_TURN_OUT;
`else
                        state     <= S_CORE;
                        HOLD      <= 1'b0;
                        slice_cnt <= 4'd0;
`endif
                    end
                end
                default: begin
                    state  <= S_CORE;
                    HOLD   <= 1'b0;
                    M1_GNT <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARBITER_TURNAROUND_EN
    // Last driven address/data, replayed while the bus is idle between owners.
    logic [15:0] addr_q;
    logic [15:0] dout_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q <= 16'd0;
            dout_q <= 16'd0;
        end else begin
            addr_q <= ADDR_BUF;
            dout_q <= DOUT_BUF;
        end
    end
`endif

    always_comb begin
        ADDR_BUF = CORE_ADDR;
        DOUT_BUF = CORE_DOUT;
        RDN_BUF  = CORE_RDN;
        WRN0_BUF = CORE_WRN0;
        WRN1_BUF = CORE_WRN1;
        DBUS_OEN = CORE_DBUS_OEN;
        case (state)
            S_DMA: begin
                ADDR_BUF = M1_ADDR;
                DOUT_BUF = M1_DOUT;
                RDN_BUF  = M1_RDN;
                WRN0_BUF = M1_WRN0;
                WRN1_BUF = M1_WRN1;
                DBUS_OEN = M1_DBUS_OEN;
            end
`ifdef BUS_ARBITER_TURNAROUND_EN
            S_TURN_IN, S_TURN_OUT: begin
                ADDR_BUF = addr_q;
                DOUT_BUF = dout_q;
                RDN_BUF  = 1'b1;
                WRN0_BUF = 1'b1;
                WRN1_BUF = 1'b1;
                DBUS_OEN = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed per-cycle vector bench for bus_arbiter (MAX_TENURE=4, CORE_SLICE=2),
// covering both builds of BUS_ARBITER_TURNAROUND_EN.
module tb_bus_arbiter;
`ifdef BUS_ARBITER_TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif
    localparam logic [1:0] OC = 2'd0, OT = 2'd1, OD = 2'd2;

    typedef struct {
        logic       req;
        logic       commit;
        logic [1:0] own;
        logic       hold;
        logic       gnt;
    } vec_t;

    logic        CLK, RESET, COMMIT, HOLD, M1_REQ, M1_GNT;
    logic [15:0] CORE_ADDR, CORE_DOUT, M1_ADDR, M1_DOUT, ADDR_BUF, DOUT_BUF;
    logic        CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN;
    logic        M1_RDN, M1_WRN0, M1_WRN1, M1_DBUS_OEN;
    logic        RDN_BUF, WRN0_BUF, WRN1_BUF, DBUS_OEN;

    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl[$];

    bus_arbiter #(.MAX_TENURE(4), .CORE_SLICE(2)) dut (
        .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT), .HOLD(HOLD),
        .CORE_ADDR(CORE_ADDR), .CORE_DOUT(CORE_DOUT), .CORE_RDN(CORE_RDN),
        .CORE_WRN0(CORE_WRN0), .CORE_WRN1(CORE_WRN1), .CORE_DBUS_OEN(CORE_DBUS_OEN),
        .M1_REQ(M1_REQ), .M1_GNT(M1_GNT), .M1_ADDR(M1_ADDR), .M1_DOUT(M1_DOUT),
        .M1_RDN(M1_RDN), .M1_WRN0(M1_WRN0), .M1_WRN1(M1_WRN1), .M1_DBUS_OEN(M1_DBUS_OEN),
        .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF), .RDN_BUF(RDN_BUF),
        .WRN0_BUF(WRN0_BUF), .WRN1_BUF(WRN1_BUF), .DBUS_OEN(DBUS_OEN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic r, input logic c, input logic [1:0] own);
        vec_t v;
        v.req = r; v.commit = c; v.own = own;
        v.hold = (own != OC);
        v.gnt  = (own == OD);
        tbl.push_back(v);
    endtask

    function automatic logic [37:0] bus_vec();
        return {HOLD, M1_GNT, ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF, DBUS_OEN};
    endfunction

    function automatic logic [37:0] core_vec();
        return {2'b00, CORE_ADDR, CORE_DOUT, CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN};
    endfunction

    initial begin
        logic [15:0] ea, ed, pa, pd;
        logic [3:0]  es;
        bit          seen;
        pa = 16'h0; pd = 16'h0;

        RESET = 1'b0; COMMIT = 1'b0; M1_REQ = 1'b1;
        CORE_ADDR = 16'h1234; CORE_DOUT = 16'h5678;
        {CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN} = 4'b0101;
        M1_ADDR = 16'h8000; M1_DOUT = 16'h9000;
        {M1_RDN, M1_WRN0, M1_WRN1, M1_DBUS_OEN} = 4'b1010;
        #3;
        chk("reset_state", bus_vec(), core_vec());
        @(negedge CLK);
        chk("reset_held", bus_vec(), core_vec());
        RESET = 1'b1;

        // First tenure: two COMMITs to qualify, ended by the tenure limit.
        push(1, 0, OC); push(1, 0, OC);
        push(1, 1, OC); push(1, 0, OC);
        push(1, 1, OC);
        if (TA) push(1, 0, OT);
        push(1, 0, OD); push(1, 1, OD); push(1, 0, OD); push(1, 0, OD);
        if (TA) push(1, 1, OT);
        // Re-grant needs two fresh COMMITs.
        push(1, 0, OC); push(1, 0, OC);
        push(1, 1, OC); push(1, 0, OC);
        push(1, 1, OC);
        if (TA) push(1, 0, OT);
        // Second tenure released by M1_REQ; toggle in TURN_OUT is ignored.
        push(1, 0, OD); push(0, 0, OD);
        if (TA) push(1, 0, OT);
        push(0, 1, OC); push(0, 1, OC); push(0, 1, OC);
        push(1, 1, OC);
        // Abort in TURN_IN, or a one-cycle tenure without turnaround.
        if (TA) push(0, 0, OT);
        else    push(0, 0, OD);
        push(0, 0, OC); push(0, 0, OC);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            M1_REQ = tbl[i].req;
            COMMIT = tbl[i].commit;
            CORE_ADDR = 16'h1000 + 16'(i);
            CORE_DOUT = 16'hC000 + 16'(i);
            M1_ADDR   = 16'h8000 + 16'(i);
            M1_DOUT   = 16'hD000 + 16'(i);
            {CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN} = 4'(i);
            {M1_RDN, M1_WRN0, M1_WRN1, M1_DBUS_OEN} = 4'(i) ^ 4'b1010;
            #1;
            case (tbl[i].own)
                OD: begin
                    ea = M1_ADDR; ed = M1_DOUT;
                    es = {M1_RDN, M1_WRN0, M1_WRN1, M1_DBUS_OEN};
                end
                OT: begin
                    ea = pa; ed = pd; es = 4'hF;
                end
                default: begin
                    ea = CORE_ADDR; ed = CORE_DOUT;
                    es = {CORE_RDN, CORE_WRN0, CORE_WRN1, CORE_DBUS_OEN};
                end
            endcase
            chk($sformatf("row%0d", i), bus_vec(), {tbl[i].hold, tbl[i].gnt, ea, ed, es});
            pa = ea; pd = ed;
        end

        // Asynchronous reset in the middle of a tenure.
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge CLK);
            M1_REQ = 1'b1; COMMIT = 1'b1;
            #1;
            seen = M1_GNT;
        end
        chk("grant_before_reset", 38'(seen), 38'd1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("reset_mid_tenure", bus_vec(), core_vec());
        @(negedge CLK);
        RESET = 1'b1; M1_REQ = 1'b1; COMMIT = 1'b1;
        @(negedge CLK);
        #1;
        chk("slice_cleared_by_reset", 38'(HOLD), 38'd0);
        @(negedge CLK);
        #1;
        chk("grant_after_reset", 38'(HOLD), 38'd1);
        M1_REQ = 1'b0; COMMIT = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        chk("idle_after_release", {HOLD, M1_GNT}, 38'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
